// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg
//   Shared definitions for the two-channel TDM receive demultiplexer.
//   - WIDTH_DEFAULT : default number of bits per channel word
//   - CH_A / CH_B   : encoding of the select line (same as the transmit mux)
//   - hold_state_e  : state of a lane's output holding register
package tdm_demux_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/tdm_demux_lane.sv
// tdm_demux_lane
//   One receive lane. It assembles WIDTH-bit words MSB-first from the bits
//   steered to it, then presents each finished word through a valid/ready
//   holding register. A word that finishes while the holding register is
//   still full and not being consumed is dropped, and the sticky overflow
//   flag is raised.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   bitValid_i in   a bit for this lane is present this cycle
//   bit_i      in   serial data bit
//   flush_i    in   discard the partially assembled word
//   clrOvf_i   in   clear the sticky overflow flag
//   ready_i    in   consumer accepts data_o this cycle
//   data_o     out  last completed word
//   valid_o    out  data_o holds an unconsumed word
//   ovf_o      out  sticky: a completed word was dropped
module tdm_demux_lane
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bitValid_i,
  input  logic             bit_i,
  input  logic             flush_i,
  input  logic             clrOvf_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] holdData_q, holdData_d;
  hold_state_e      holdState_q, holdState_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] nextWord;
  logic             wordDone;

  // Assembly and holding logic. Flush has priority over an incoming bit, so
  // a bit arriving together with flush is discarded. When a word completes
  // it is taken straight from the shift path, so the holding register sees
  // it on the same edge that the last bit is shifted in. An overflow set in
  // the same cycle as clrOvf_i wins because it is applied after the clear.
  always_comb begin
    shiftReg_d  = shiftReg_q;
    bitCnt_d    = bitCnt_q;
    holdData_d  = holdData_q;
    holdState_d = holdState_q;
    ovf_d       = ovf_q & ~clrOvf_i;
    nextWord    = {shiftReg_q[WIDTH-2:0], bit_i};
    wordDone    = 1'b0;

    if (flush_i) begin
      shiftReg_d = '0;
      bitCnt_d   = '0;
    end else if (bitValid_i) begin
      shiftReg_d = nextWord;
      if (bitCnt_q == LastBit) begin
        bitCnt_d = '0;
        wordDone = 1'b1;
      end else begin
        bitCnt_d = bitCnt_q + CNT_W'(1);
      end
    end

    case (holdState_q)
      HOLD_EMPTY: begin
        if (wordDone) begin
          holdData_d  = nextWord;
          holdState_d = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (wordDone) begin
          if (ready_i) begin
            holdData_d = nextWord;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ready_i) begin
          holdState_d = HOLD_EMPTY;
        end
      end
    endcase
  end

  // State register for the whole lane; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg_q  <= '0;
      bitCnt_q    <= '0;
      holdData_q  <= '0;
      holdState_q <= HOLD_EMPTY;
      ovf_q       <= 1'b0;
    end else begin
      shiftReg_q  <= shiftReg_d;
      bitCnt_q    <= bitCnt_d;
      holdData_q  <= holdData_d;
      holdState_q <= holdState_d;
      ovf_q       <= ovf_d;
    end
  end

  assign data_o  = holdData_q;
  assign valid_o = (holdState_q == HOLD_FULL);
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/tdm_demux_2ch.sv
// tdm_demux_2ch
//   Receive-side demultiplexer for a two-channel time-division multiplexed
//   serial line. Each qualified bit is steered by sel to lane A (sel=0) or
//   lane B (sel=1); each lane builds MSB-first words and offers them through
//   its own valid/ready output with a sticky overflow flag.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   bit_in, sel      serial data and its channel select
//   bit_valid        qualifies bit_in/sel this cycle
//   flush            discard partial words in both lanes
//   clr_ovf          clear both overflow flags
//   a_data/a_valid/a_ready/a_ovf   channel A word output
//   b_data/b_valid/b_ready/b_ovf   channel B word output
module tdm_demux_2ch
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             sel,
  input  logic             bit_valid,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             a_ovf,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             b_ovf
);

  logic laneAValid;
  logic laneBValid;

  assign laneAValid = bit_valid & (sel == CH_A);
  assign laneBValid = bit_valid & (sel == CH_B);

  tdm_demux_lane #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_laneA (
    .clk        (clk),
    .rst        (rst),
    .bitValid_i (laneAValid),
    .bit_i      (bit_in),
    .flush_i    (flush),
    .clrOvf_i   (clr_ovf),
    .ready_i    (a_ready),
    .data_o     (a_data),
    .valid_o    (a_valid),
    .ovf_o      (a_ovf)
  );

  tdm_demux_lane #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_laneB (
    .clk        (clk),
    .rst        (rst),
    .bitValid_i (laneBValid),
    .bit_i      (bit_in),
    .flush_i    (flush),
    .clrOvf_i   (clr_ovf),
    .ready_i    (b_ready),
    .data_o     (b_data),
    .valid_o    (b_valid),
    .ovf_o      (b_ovf)
  );

endmodule

// File: doc/tdm_demux_2ch.md
Name: tdm_demux_2ch

Overview:
- Receive-side counterpart of the 2:1 channel mux: one serial line carries bits from two channels, time-division multiplexed under a select bit.
- Steers each qualified bit to the lane named by `sel` (0 = A, 1 = B; same encoding as the mux select).
- Each lane assembles WIDTH-bit words MSB-first and presents each complete word through a valid/ready output.
- Sits between the top-level pin wrapper (ui_in bits, uo_out/uio_out) and downstream consumers.

Parameters:
- WIDTH, 4, bits per channel word; legal range 2..8.
- CNT_W, $clog2(WIDTH), width of the per-lane bit counter.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- bit_in  in  1  serial data from the multiplexed line
- sel  in  1  channel select for bit_in: 0 = A, 1 = B
- bit_valid  in  1  qualifies bit_in/sel this cycle
- flush  in  1  discard partial words in both lanes
- clr_ovf  in  1  clear both overflow flags
- a_data  out  WIDTH  channel A completed word
- a_valid  out  1  a_data holds an unconsumed word
- a_ready  in  1  consumer accepts a_data
- a_ovf  out  1  sticky: channel A word dropped
- b_data  out  WIDTH  channel B completed word
- b_valid  out  1  b_data holds an unconsumed word
- b_ready  in  1  consumer accepts b_data
- b_ovf  out  1  sticky: channel B word dropped

Behaviour:
- Reset (rst=1 at a clock edge): all shift registers, counters, holding registers, valid flags and overflow flags go to 0. All outputs read 0 the cycle after. Reset mid-word discards the partial word.
- Bit acceptance: the lane selected by `sel` accepts a bit when bit_valid=1. That lane shifts left, bit_in entering the LSB: sreg <= {sreg[WIDTH-2:0], bit_in}. Its counter increments. The other lane is untouched. When bit_valid=0, sel and bit_in are don't-care.
- Word completion: a word completes when the lane accepts a bit while its counter = WIDTH-1. The counter wraps to 0 on the same edge. The completed word is {sreg[WIDTH-2:0], bit_in}.
- Holding register, two states per lane:
  - EMPTY (valid=0):
    - Word completes -> load data, go to FULL.
    - x_valid rises on the edge after the last bit is accepted (latency 1 cycle).
  - FULL (valid=1):
    - ready=1 and no completion -> go to EMPTY; data holds its last value.
    - ready=1 and a completion on the same cycle -> load the new word and stay FULL. No bubble, no overflow.
    - ready=0 and a completion -> word dropped. data is unchanged. x_ovf is set on that edge.
- Output stability: x_data is stable while x_valid=1 and ready=0.
- Overflow flags: x_ovf is sticky until clr_ovf=1 or rst. If a set and clr_ovf occur on the same cycle, the set wins (flag ends at 1).
- flush: clears both sreg and both counters. Holding registers, valid flags and ovf flags are unaffected. If flush and bit_valid are asserted on the same cycle, flush wins and the bit is discarded.
- Lane independence: no cross-lane coupling. A and B may each complete words in any interleaving, including alternating every cycle.
- Throughput: one bit per cycle total on the line. With ready held at 1, no lane ever overflows.
- Implementation: no combinational path from bit_in/sel to any output; all outputs are registered.

Decomposition:
- Package tdm_demux_pkg:
  - WIDTH_DEFAULT = 4
  - channel encoding constants CH_A = 1'b0, CH_B = 1'b1
  - lane holding-state enum {HOLD_EMPTY, HOLD_FULL}
- Sub-module tdm_demux_lane, instantiated twice:
  - Inputs: bit_valid & (sel == CH_x), bit_in, flush, ready, clr_ovf.
  - Contains the shift register, counter, holding register, valid and ovf.
- Top level: select decode and port wiring only.

Test Plan (WIDTH=4):
1. sel=0, bits 1,0,1,1 on consecutive cycles, a_ready=0 -> a_data=4'hB and a_valid=1 exactly one cycle after the 4th bit; b_valid=0, a_ovf=0.
2. Interleave A1,B0,A0,B1,A1,B1,A0,B0, with bit_valid=0 gaps inserted between some bits -> a_data=4'hA, b_data=4'h6, both valid; the gaps do not change either result.
3. a_ready=0; send A word 0xB then A word 0x5 -> a_data stays 0xB and a_ovf=1. Pulse clr_ovf -> a_ovf=0. Pulse a_ready -> a_valid=0 next cycle.
4. a_ready=1 held; stream 0x3,0xC,0x9 on A back-to-back -> three one-cycle a_valid pulses carrying 3, C, 9; a_ovf stays 0. Repeat with the completion coinciding with ready -> no drop.
5. Send A bits 1,1, then flush, then 0,0,1,1 -> a_data=4'h3 (not mixed with the flushed bits). Also assert flush together with bit_valid -> that bit is ignored.
6. Send 2 bits on B, assert rst for 1 cycle -> all outputs 0. Then send B bits 0,1,1,0 -> b_data=4'h6 and b_valid=1; there is no spurious earlier completion.
